// File: rtl/score_digits_drawer.sv
// -----------------------------------------------------------------------------
// score_digits_drawer
//
// Pixel-path stage that sits behind the bracket object. It keeps the game
// score as a saturating 3-digit BCD accumulator, latches a shadow copy of it
// at every frame start, and renders that shadow as three 16x32 digits inside
// a 48x32 bracket.
//
// Ports:
//   clk              system clock (posedge)
//   resetN           asynchronous active-low reset
//   offsetX/offsetY  pixel offset inside the bracket (from upstream)
//   InsideRectangle  upstream drawing request
//   startOfFrame     one-cycle pulse, latches the displayed (shadow) score
//   addPoints        one-cycle pulse, adds addValue (0..9, 10..15 -> 9)
//   addValue         points to add
//   clearScore       clears score and saturation flag (wins over addPoints)
//   drawingRequest   registered: current pixel is a lit digit pixel
//   RGBout           registered: DIGIT_COLOR when lit, else 8'hFF
//   scoreBCD         live score {hundreds, tens, units}
//   maxReached       sticky flag, set when an add saturates
// -----------------------------------------------------------------------------
module score_digits_drawer #(
    parameter logic [7:0] DIGIT_COLOR            = 8'hFC,
    parameter int         SCORE_MAX              = 999,
    parameter bit         SUPPRESS_LEADING_ZEROS = 1'b1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    input  logic        startOfFrame,
    input  logic        addPoints,
    input  logic [3:0]  addValue,
    input  logic        clearScore,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [11:0] scoreBCD,
    output logic        maxReached
);

    localparam logic [11:0] MAX_BCD = {4'((SCORE_MAX / 100) % 10),
                                       4'((SCORE_MAX / 10) % 10),
                                       4'(SCORE_MAX % 10)};

    // ------------------------------------------------------------------
    // Font: seven-segment style glyphs drawn on a 16x32 cell with a
    // one-pixel empty border. Digit 1 is a centred two-pixel stroke so it
    // does not hug the right edge. Bit (15-col) holds column col.
    // ------------------------------------------------------------------
    function automatic logic [15:0] glyph_row(input int digit, input int row);
        logic [6:0]  seg;   // {a,b,c,d,e,f,g}
        logic [15:0] bits;
        logic        lit, hcol, left_col, right_col;
        logic        top_r, mid_r, bot_r, upper_r, lower_r;
        bits = '0;
        case (digit)
            0:       seg = 7'b1111110;
            2:       seg = 7'b1101101;
            3:       seg = 7'b1111001;
            4:       seg = 7'b0110011;
            5:       seg = 7'b1011011;
            6:       seg = 7'b1011111;
            7:       seg = 7'b1110000;
            8:       seg = 7'b1111111;
            9:       seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        top_r   = (row >= 4)  && (row <= 5);
        mid_r   = (row >= 15) && (row <= 16);
        bot_r   = (row >= 26) && (row <= 27);
        upper_r = (row >= 4)  && (row <= 15);
        lower_r = (row >= 16) && (row <= 27);
        for (int c = 0; c < 16; c++) begin
            hcol      = (c >= 2)  && (c <= 13);
            left_col  = (c >= 2)  && (c <= 3);
            right_col = (c >= 12) && (c <= 13);
            if (digit == 1) begin
                lit = ((c == 7) || (c == 8)) && (row >= 4) && (row <= 27);
            end else begin
                lit = (seg[6] && top_r   && hcol)      ||
                      (seg[5] && upper_r && right_col) ||
                      (seg[4] && lower_r && right_col) ||
                      (seg[3] && bot_r   && hcol)      ||
                      (seg[2] && lower_r && left_col)  ||
                      (seg[1] && upper_r && left_col)  ||
                      (seg[0] && mid_r   && hcol);
            end
            bits[4'(15 - c)] = lit;
        end
        return bits;
    endfunction

    // Entry index is {digit, row}: 10 digits x 32 rows.
    logic [15:0] font_rom [0:319];

    generate
        for (genvar gi = 0; gi < 320; gi++) begin : g_font
            assign font_rom[gi] = glyph_row(gi / 32, gi % 32);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Score state
    // ------------------------------------------------------------------
    logic [11:0] score_reg, score_next;
    logic [11:0] shadow_reg;
    logic        max_reg, max_next;
    logic        draw_reg, draw_next;
    logic [7:0]  rgb_reg, rgb_next;

    logic [3:0]  add_val;
    logic [2:0]  carry;
    logic [11:0] sum_bcd;
    logic        overflow;

    assign add_val = (addValue > 4'd9) ? 4'd9 : addValue;

    // Ripple BCD adder: units gets add_val, higher digits get the carry in.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
            logic [3:0] addend;
            logic [4:0] dsum;
            if (gi == 0) begin : g_lsd
                assign addend = add_val;
            end else begin : g_upper
                assign addend = {3'b000, carry[gi-1]};
            end
            assign dsum                 = {1'b0, score_reg[4*gi +: 4]} + {1'b0, addend};
            assign carry[gi]            = (dsum > 5'd9);
            assign sum_bcd[4*gi +: 4]   = carry[gi] ? 4'(dsum - 5'd10) : dsum[3:0];
        end
    endgenerate

    // With legal BCD digits, a plain unsigned compare orders the values
    // the same way as their decimal meaning.
    assign overflow = carry[2] || (sum_bcd > MAX_BCD);

    always_comb begin
        score_next = score_reg;
        max_next   = max_reg;
        if (clearScore) begin
            score_next = '0;
            max_next   = 1'b0;
        end else if (addPoints) begin
            if (overflow) begin
                score_next = MAX_BCD;
                max_next   = 1'b1;
            end else begin
                score_next = sum_bcd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel path (one register stage)
    // ------------------------------------------------------------------
    logic [6:0]  digit_idx;
    logic [3:0]  col;
    logic [4:0]  row;
    logic [3:0]  cur_digit;
    logic        in_bounds, blank;
    logic [15:0] rom_row;

    assign digit_idx = offsetX[10:4];
    assign col       = offsetX[3:0];
    assign row       = offsetY[4:0];
    assign in_bounds = InsideRectangle && (offsetX < 11'd48) && (offsetY < 11'd32);

    always_comb begin
        cur_digit = shadow_reg[3:0];
        if (digit_idx == 7'd0) begin
            cur_digit = shadow_reg[11:8];
        end else if (digit_idx == 7'd1) begin
            cur_digit = shadow_reg[7:4];
        end
    end

    assign blank = SUPPRESS_LEADING_ZEROS &&
                   (((digit_idx == 7'd0) && (shadow_reg[11:8] == 4'd0)) ||
                    ((digit_idx == 7'd1) && (shadow_reg[11:4] == 8'd0)));

    assign rom_row = font_rom[{cur_digit, row}];

    always_comb begin
        draw_next = in_bounds && !blank && rom_row[~col];  // ~col == 15-col
        rgb_next  = draw_next ? DIGIT_COLOR : 8'hFF;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            score_reg  <= '0;
            shadow_reg <= '0;
            max_reg    <= 1'b0;
            draw_reg   <= 1'b0;
            rgb_reg    <= 8'hFF;
        end else begin
            score_reg <= score_next;
            max_reg   <= max_next;
            if (startOfFrame) begin
                shadow_reg <= score_reg;  // pre-update value on a same-cycle add
            end
            draw_reg <= draw_next;
            rgb_reg  <= rgb_next;
        end
    end

    assign drawingRequest = draw_reg;
    assign RGBout         = rgb_reg;
    assign scoreBCD       = score_reg;
    assign maxReached     = max_reg;

endmodule

// File: tb/tb_score_digits_drawer.sv
// -----------------------------------------------------------------------------
// Testbench for score_digits_drawer. The reference model keeps the score as a
// plain integer, and knows the glyphs only through their guaranteed
// properties (empty border, digit 0 sides and hollow centre, digit 1 stroke);
// pixels outside those properties are checked only for colour consistency.
// -----------------------------------------------------------------------------
module tb_score_digits_drawer;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] offsetX, offsetY;
    logic        InsideRectangle, startOfFrame, addPoints, clearScore;
    logic [3:0]  addValue;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [11:0] scoreBCD;
    logic        maxReached;

    int checks = 0;
    int errors = 0;

    // model state
    int m_score, m_shadow, m_max, m_pix;

    always #5 clk = ~clk;

    score_digits_drawer #(
        .DIGIT_COLOR(8'hFC),
        .SCORE_MAX(999),
        .SUPPRESS_LEADING_ZEROS(1'b1)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .offsetX(offsetX),
        .offsetY(offsetY),
        .InsideRectangle(InsideRectangle),
        .startOfFrame(startOfFrame),
        .addPoints(addPoints),
        .addValue(addValue),
        .clearScore(clearScore),
        .drawingRequest(drawingRequest),
        .RGBout(RGBout),
        .scoreBCD(scoreBCD),
        .maxReached(maxReached)
    );

    function automatic logic [11:0] to_bcd(input int s);
        return {4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // 0 = must be dark, 1 = must be lit, 2 = glyph detail not pinned down
    function automatic int exp_pixel(input int shadow, input int x, input int y, input int ins);
        int idx, c, r, d;
        if (ins == 0 || x >= 48 || y >= 32) return 0;
        idx = x / 16;
        c   = x % 16;
        r   = y;
        if (idx == 0 && shadow < 100) return 0;
        if (idx == 1 && shadow < 10)  return 0;
        d = (idx == 0) ? (shadow / 100) : (idx == 1) ? ((shadow / 10) % 10) : (shadow % 10);
        if (r == 0 || r == 31 || c == 0 || c == 15) return 0;
        if (d == 1 && (c == 7 || c == 8) && r >= 4 && r <= 27) return 1;
        if (d == 0 && r >= 8 && r <= 23) begin
            if (c == 2 || c == 3 || c == 12 || c == 13) return 1;
            if (c >= 6 && c <= 9) return 0;
        end
        return 2;
    endfunction

    // Apply current inputs for one clock; the model follows the same edge.
    task automatic step();
        int v, nshadow;
        if (!resetN) begin
            m_score = 0; m_shadow = 0; m_max = 0; m_pix = 0;
        end else begin
            m_pix   = exp_pixel(m_shadow, int'(offsetX), int'(offsetY), int'(InsideRectangle));
            nshadow = startOfFrame ? m_score : m_shadow;
            if (clearScore) begin
                m_score = 0;
                m_max   = 0;
            end else if (addPoints) begin
                v = (addValue > 9) ? 9 : int'(addValue);
                if (m_score + v > 999) begin
                    m_score = 999;
                    m_max   = 1;
                end else begin
                    m_score = m_score + v;
                end
            end
            m_shadow = nshadow;
        end
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        addPoints    = 1'b0;
        clearScore   = 1'b0;
    endtask

    task automatic set_pixel(input int x, input int y, input logic ins);
        offsetX         = 11'(x);
        offsetY         = 11'(y);
        InsideRectangle = ins;
    endtask

    task automatic add(input int v);
        addPoints = 1'b1;
        addValue  = 4'(v);
        step();
        $display("add %0d -> score %03h max %0d", v, scoreBCD, maxReached);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        set_pixel(34, 16, 1'b1);
        startOfFrame = 0; addPoints = 0; clearScore = 0; addValue = 0;
        m_score = 0; m_shadow = 0; m_max = 0; m_pix = 0;
        repeat (3) @(posedge clk);
        #1;
        if (drawingRequest !== 1'b0) begin errors++; $display("FAIL reset_draw got %b want 0", drawingRequest); end
        checks++;
        if (RGBout !== 8'hFF) begin errors++; $display("FAIL reset_rgb got %h want ff", RGBout); end
        checks++;
        if (scoreBCD !== 12'h000) begin errors++; $display("FAIL reset_score got %h want 000", scoreBCD); end
        checks++;
        if (maxReached !== 1'b0) begin errors++; $display("FAIL reset_max got %b want 0", maxReached); end
        checks++;
        resetN = 1'b1;
        set_pixel(0, 0, 1'b0);
        step();
        $display("reset released");
    endtask

    task automatic test_empty_frame();
        startOfFrame = 1'b1;
        step();
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 48; x++) begin
                set_pixel(x, y, 1'b1);
                step();
                if (m_pix != 2 && drawingRequest !== m_pix[0]) begin
                    errors++;
                    $display("FAIL sweep0_draw x=%0d y=%0d got %b want %0d", x, y, drawingRequest, m_pix);
                end
                checks++;
                if (RGBout !== (drawingRequest ? 8'hFC : 8'hFF)) begin
                    errors++;
                    $display("FAIL sweep0_rgb x=%0d y=%0d got %h with draw %b", x, y, RGBout, drawingRequest);
                end
                checks++;
            end
        end
        $display("sweep of score 0 done");
        // latency: dark pixel, then units pixel; output flips only after the edge
        set_pixel(0, 16, 1'b1);
        step();
        set_pixel(34, 16, 1'b1);
        #1;
        if (drawingRequest !== 1'b0) begin errors++; $display("FAIL latency_pre got %b want 0", drawingRequest); end
        checks++;
        step();
        if (drawingRequest !== 1'b1 || RGBout !== 8'hFC) begin
            errors++;
            $display("FAIL units_pixel got draw %b rgb %h want 1 fc", drawingRequest, RGBout);
        end
        checks++;
    endtask

    task automatic test_carry();
        clearScore = 1'b1;
        step();
        add(7);
        if (scoreBCD !== 12'h007) begin errors++; $display("FAIL carry_add7 got %h want 007", scoreBCD); end
        checks++;
        add(5);
        if (scoreBCD !== 12'h012) begin errors++; $display("FAIL carry_add5 got %h want 012", scoreBCD); end
        checks++;
        set_pixel(23, 16, 1'b1);
        step();
        if (drawingRequest !== 1'b0) begin errors++; $display("FAIL tens_before_sof got %b want 0", drawingRequest); end
        checks++;
        startOfFrame = 1'b1;
        step();
        set_pixel(23, 16, 1'b1);
        step();
        if (drawingRequest !== 1'b1 || RGBout !== 8'hFC) begin
            errors++;
            $display("FAIL tens_after_sof got draw %b rgb %h want 1 fc", drawingRequest, RGBout);
        end
        checks++;
        set_pixel(8, 16, 1'b1);
        step();
        if (drawingRequest !== 1'b0) begin errors++; $display("FAIL hundreds_blank got %b want 0", drawingRequest); end
        checks++;
    endtask

    task automatic test_saturation();
        clearScore = 1'b1;
        step();
        add(15);
        if (scoreBCD !== 12'h009) begin errors++; $display("FAIL add15_as_9 got %h want 009", scoreBCD); end
        checks++;
        for (int i = 0; i < 109; i++) begin
            add(9);
        end
        add(5);
        if (scoreBCD !== 12'h995 || maxReached !== 1'b0) begin
            errors++;
            $display("FAIL preload995 got %h max %b want 995 0", scoreBCD, maxReached);
        end
        checks++;
        add(9);
        if (scoreBCD !== 12'h999 || maxReached !== 1'b1) begin
            errors++;
            $display("FAIL saturate got %h max %b want 999 1", scoreBCD, maxReached);
        end
        checks++;
        add(0);
        if (scoreBCD !== 12'h999 || maxReached !== 1'b1) begin
            errors++;
            $display("FAIL add0_at_max got %h max %b want 999 1", scoreBCD, maxReached);
        end
        checks++;
        clearScore = 1'b1;
        add(4);
        if (scoreBCD !== 12'h000 || maxReached !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority got %h max %b want 000 0", scoreBCD, maxReached);
        end
        checks++;
    endtask

    task automatic test_shadow_same_cycle();
        clearScore = 1'b1;
        step();
        add(4);
        startOfFrame = 1'b1;
        add(3);
        if (scoreBCD !== 12'h007) begin errors++; $display("FAIL live_after_sof_add got %h want 007", scoreBCD); end
        checks++;
        // score 9, then frame start together with +1: display must still show 9
        clearScore = 1'b1;
        step();
        add(9);
        startOfFrame = 1'b1;
        add(1);
        if (scoreBCD !== 12'h010) begin errors++; $display("FAIL live_10 got %h want 010", scoreBCD); end
        checks++;
        set_pixel(23, 16, 1'b1);
        step();
        if (drawingRequest !== m_pix[0]) begin
            errors++;
            $display("FAIL shadow_pre_update got %b want %0d", drawingRequest, m_pix);
        end
        checks++;
        startOfFrame = 1'b1;
        step();
        set_pixel(23, 16, 1'b1);
        step();
        if (drawingRequest !== m_pix[0]) begin
            errors++;
            $display("FAIL shadow_10_tens got %b want %0d", drawingRequest, m_pix);
        end
        checks++;
        set_pixel(34, 16, 1'b1);
        step();
        if (drawingRequest !== m_pix[0]) begin
            errors++;
            $display("FAIL shadow_10_units got %b want %0d", drawingRequest, m_pix);
        end
        checks++;
    endtask

    task automatic test_bounds();
        int xs [4] = '{48, 34, 34, 2047};
        int ys [4] = '{16, 32, 16, 16};
        logic ins [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            set_pixel(xs[i], ys[i], ins[i]);
            step();
            if (drawingRequest !== 1'b0 || RGBout !== 8'hFF) begin
                errors++;
                $display("FAIL bounds_%0d x=%0d y=%0d ins=%b got draw %b rgb %h want 0 ff",
                         i, xs[i], ys[i], ins[i], drawingRequest, RGBout);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clearScore   = ($urandom_range(0, 31) == 0);
            addPoints    = ($urandom_range(0, 1) == 1);
            addValue     = 4'($urandom_range(0, 15));
            startOfFrame = ($urandom_range(0, 7) == 0);
            set_pixel(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 47)),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 31)),
                      ($urandom_range(0, 3) != 0));
            step();
            $display("rand %0d score %03h max %0d draw %0d", n, scoreBCD, maxReached, drawingRequest);
            if (scoreBCD !== to_bcd(m_score) || maxReached !== m_max[0]) begin
                errors++;
                $display("FAIL rand_score n=%0d got %h max %b want %h max %0d",
                         n, scoreBCD, maxReached, to_bcd(m_score), m_max);
            end
            checks++;
            if (m_pix != 2 && drawingRequest !== m_pix[0]) begin
                errors++;
                $display("FAIL rand_pixel n=%0d got %b want %0d", n, drawingRequest, m_pix);
            end
            checks++;
            if (RGBout !== (drawingRequest ? 8'hFC : 8'hFF)) begin
                errors++;
                $display("FAIL rand_rgb n=%0d got %h with draw %b", n, RGBout, drawingRequest);
            end
            checks++;
        end
    endtask

    task automatic test_async_reset();
        clearScore = 1'b1;
        step();
        add(9);
        add(1);
        startOfFrame = 1'b1;
        step();
        set_pixel(23, 16, 1'b1);
        step();
        if (drawingRequest !== 1'b1) begin errors++; $display("FAIL pre_reset_lit got %b want 1", drawingRequest); end
        checks++;
        resetN = 1'b0;
        #1;
        if (drawingRequest !== 1'b0 || RGBout !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset_pixel got draw %b rgb %h want 0 ff", drawingRequest, RGBout);
        end
        checks++;
        if (scoreBCD !== 12'h000 || maxReached !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_score got %h max %b want 000 0", scoreBCD, maxReached);
        end
        checks++;
        step();
        resetN = 1'b1;
        set_pixel(23, 16, 1'b1);
        step();
        if (drawingRequest !== 1'b0) begin errors++; $display("FAIL post_reset_tens got %b want 0", drawingRequest); end
        checks++;
        set_pixel(34, 16, 1'b1);
        step();
        if (drawingRequest !== 1'b1) begin errors++; $display("FAIL post_reset_units got %b want 1", drawingRequest); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_carry();
        test_saturation();
        test_shadow_same_cycle();
        test_bounds();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
